// File: rtl/sobel_stream_3x3.sv
// Streaming 3x3 Sobel engine: raster pixels in, Gy / Gx / |Gx|+|Gy| out
// for every interior pixel, with two internal line buffers.
//
// Ports:
//   clk, rst            rising-edge clock, async active-high reset
//   in_pix, in_valid    pixel stream, one pixel per valid cycle, no backpressure
//   in_sof              with in_valid: pixel is (row 0, col 0)
//   mode                0=Gy 1=Gx 2/3=|Gx|+|Gy|, latched on accepted in_sof
//   out_grad            result, signed in modes 0/1, unsigned in mode 2
//   out_valid/eol/eof   result strobe, last interior column, last interior pixel
module sobel_stream_3x3 #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] in_pix,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [1:0]       mode,
  output logic [PIX_W+3:0] out_grad,
  output logic             out_valid,
  output logic             out_eol,
  output logic             out_eof
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int GW = PIX_W + 3;
  localparam int OW = PIX_W + 4;

  typedef struct packed {
    logic [PIX_W-1:0] t0, t1, t2;
    logic [PIX_W-1:0] m0, m2;
    logic [PIX_W-1:0] b0, b1, b2;
  } win_t;

  // line buffer 1 holds row r-1, line buffer 2 holds row r-2
  logic [PIX_W-1:0] lb1_mem [IMG_W];
  logic [PIX_W-1:0] lb2_mem [IMG_W];

  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [1:0]       mode_q, mode_d;

  // columns c-1 (m1) and c-2 (m2) of each window row
  logic [PIX_W-1:0] top_m1_q, top_m1_d, top_m2_q, top_m2_d;
  logic [PIX_W-1:0] mid_m1_q, mid_m1_d, mid_m2_q, mid_m2_d;
  logic [PIX_W-1:0] bot_m1_q, bot_m1_d, bot_m2_q, bot_m2_d;

  win_t             a_win_q, a_win_d;
  logic             a_vld_q, a_vld_d;
  logic             a_eol_q, a_eol_d;
  logic             a_eof_q, a_eof_d;
  logic [1:0]       a_mode_q, a_mode_d;

  logic signed [GW-1:0] b_gx_q, b_gx_d;
  logic signed [GW-1:0] b_gy_q, b_gy_d;
  logic             b_vld_q, b_vld_d;
  logic             b_eol_q, b_eol_d;
  logic             b_eof_q, b_eof_d;
  logic [1:0]       b_mode_q, b_mode_d;

  logic [OW-1:0]    out_grad_q, out_grad_d;
  logic             out_vld_q, out_vld_d;
  logic             out_eol_q, out_eol_d;
  logic             out_eof_q, out_eof_d;

  logic [CW-1:0]    col_e;
  logic [RW-1:0]    row_e;
  logic [PIX_W-1:0] top_cur, mid_cur;
  logic             last_col, last_row, win_hit;
  logic [GW-1:0]    gy_p, gy_n, gx_p, gx_n;
  logic [GW-1:0]    mag_x, mag_y;

  // an accepted in_sof restarts the frame on this very pixel
  always_comb begin
    col_e    = in_sof ? '0 : col_q;
    row_e    = in_sof ? '0 : row_q;
    top_cur  = lb2_mem[col_e];
    mid_cur  = lb1_mem[col_e];
    last_col = (col_e == CW'(IMG_W - 1));
    last_row = (row_e == RW'(IMG_H - 1));
    win_hit  = in_valid && (col_e >= CW'(2)) && (row_e >= RW'(2));
  end

  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    mode_d   = mode_q;
    top_m1_d = top_m1_q;
    top_m2_d = top_m2_q;
    mid_m1_d = mid_m1_q;
    mid_m2_d = mid_m2_q;
    bot_m1_d = bot_m1_q;
    bot_m2_d = bot_m2_q;
    if (in_valid) begin
      col_d    = last_col ? '0 : col_e + 1'b1;
      row_d    = last_col ? (last_row ? '0 : row_e + 1'b1) : row_e;
      if (in_sof) mode_d = mode;
      top_m2_d = top_m1_q;
      top_m1_d = top_cur;
      mid_m2_d = mid_m1_q;
      mid_m1_d = mid_cur;
      bot_m2_d = bot_m1_q;
      bot_m1_d = in_pix;
    end
  end

  // stage A: capture the completed window
  always_comb begin
    a_win_d  = a_win_q;
    a_vld_d  = win_hit;
    a_eol_d  = win_hit && last_col;
    a_eof_d  = win_hit && last_col && last_row;
    a_mode_d = mode_q;
    if (win_hit) begin
      a_win_d.t0 = top_m2_q;
      a_win_d.t1 = top_m1_q;
      a_win_d.t2 = top_cur;
      a_win_d.m0 = mid_m2_q;
      a_win_d.m2 = mid_cur;
      a_win_d.b0 = bot_m2_q;
      a_win_d.b1 = bot_m1_q;
      a_win_d.b2 = in_pix;
    end
  end

  // stage B: signed gradients
  always_comb begin
    gy_p = GW'(a_win_q.b0) + (GW'(a_win_q.b1) << 1) + GW'(a_win_q.b2);
    gy_n = GW'(a_win_q.t0) + (GW'(a_win_q.t1) << 1) + GW'(a_win_q.t2);
    gx_p = GW'(a_win_q.t2) + (GW'(a_win_q.m2) << 1) + GW'(a_win_q.b2);
    gx_n = GW'(a_win_q.t0) + (GW'(a_win_q.m0) << 1) + GW'(a_win_q.b0);
    b_gy_d   = gy_p - gy_n;
    b_gx_d   = gx_p - gx_n;
    b_vld_d  = a_vld_q;
    b_eol_d  = a_eol_q;
    b_eof_d  = a_eof_q;
    b_mode_d = a_mode_q;
  end

  // stage C: select result; out_grad holds between strobes
  always_comb begin
    mag_x      = b_gx_q[GW-1] ? -b_gx_q : b_gx_q;
    mag_y      = b_gy_q[GW-1] ? -b_gy_q : b_gy_q;
    out_grad_d = out_grad_q;
    if (b_vld_q) begin
      case (b_mode_q)
        2'd0:    out_grad_d = {b_gy_q[GW-1], b_gy_q};
        2'd1:    out_grad_d = {b_gx_q[GW-1], b_gx_q};
        default: out_grad_d = OW'(mag_x) + OW'(mag_y);
      endcase
    end
    out_vld_d = b_vld_q;
    out_eol_d = b_vld_q && b_eol_q;
    out_eof_d = b_vld_q && b_eof_q;
  end

  // line buffers are not reset; the row gate masks stale contents
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb2_mem[col_e] <= mid_cur;
      lb1_mem[col_e] <= in_pix;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q      <= '0;
      row_q      <= '0;
      mode_q     <= '0;
      top_m1_q   <= '0;
      top_m2_q   <= '0;
      mid_m1_q   <= '0;
      mid_m2_q   <= '0;
      bot_m1_q   <= '0;
      bot_m2_q   <= '0;
      a_win_q    <= '0;
      a_vld_q    <= 1'b0;
      a_eol_q    <= 1'b0;
      a_eof_q    <= 1'b0;
      a_mode_q   <= '0;
      b_gx_q     <= '0;
      b_gy_q     <= '0;
      b_vld_q    <= 1'b0;
      b_eol_q    <= 1'b0;
      b_eof_q    <= 1'b0;
      b_mode_q   <= '0;
      out_grad_q <= '0;
      out_vld_q  <= 1'b0;
      out_eol_q  <= 1'b0;
      out_eof_q  <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      mode_q     <= mode_d;
      top_m1_q   <= top_m1_d;
      top_m2_q   <= top_m2_d;
      mid_m1_q   <= mid_m1_d;
      mid_m2_q   <= mid_m2_d;
      bot_m1_q   <= bot_m1_d;
      bot_m2_q   <= bot_m2_d;
      a_win_q    <= a_win_d;
      a_vld_q    <= a_vld_d;
      a_eol_q    <= a_eol_d;
      a_eof_q    <= a_eof_d;
      a_mode_q   <= a_mode_d;
      b_gx_q     <= b_gx_d;
      b_gy_q     <= b_gy_d;
      b_vld_q    <= b_vld_d;
      b_eol_q    <= b_eol_d;
      b_eof_q    <= b_eof_d;
      b_mode_q   <= b_mode_d;
      out_grad_q <= out_grad_d;
      out_vld_q  <= out_vld_d;
      out_eol_q  <= out_eol_d;
      out_eof_q  <= out_eof_d;
    end
  end

  assign out_grad  = out_grad_q;
  assign out_valid = out_vld_q;
  assign out_eol   = out_eol_q;
  assign out_eof   = out_eof_q;

endmodule

// File: tb/tb_sobel_stream_3x3.sv
// Testbench for sobel_stream_3x3: directed frames with random pixels/gaps
// checked cycle-exactly against a frame-array Sobel model.
module tb_sobel_stream_3x3;

  localparam int PW = 8;
  localparam int W  = 8;
  localparam int H  = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] in_pix;
  logic          in_valid;
  logic          in_sof;
  logic [1:0]    mode;
  logic [PW+3:0] out_grad;
  logic          out_valid;
  logic          out_eol;
  logic          out_eof;

  sobel_stream_3x3 #(.PIX_W(PW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst),
    .in_pix(in_pix), .in_valid(in_valid), .in_sof(in_sof), .mode(mode),
    .out_grad(out_grad), .out_valid(out_valid),
    .out_eol(out_eol), .out_eof(out_eof)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [11:0] g;
    logic        eol;
    logic        eof;
  } exp_t;

  exp_t        exp_q[$];
  int          frame[H][W];
  int          cyc;
  int          vectors;
  int          miscompares;
  logic [11:0] last_grad;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)",
             tag, obs, expv, cyc);
    end
  endtask

  function automatic logic [11:0] model(input int r, input int c,
                                        input logic [1:0] md);
    int gy, gx, v;
    logic [31:0] u;
    gy = (frame[r][c-2] + 2*frame[r][c-1] + frame[r][c])
       - (frame[r-2][c-2] + 2*frame[r-2][c-1] + frame[r-2][c]);
    gx = (frame[r-2][c] + 2*frame[r-1][c] + frame[r][c])
       - (frame[r-2][c-2] + 2*frame[r-1][c-2] + frame[r][c-2]);
    if (md == 2'd0)      v = gy;
    else if (md == 2'd1) v = gx;
    else v = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    u = v;
    return u[11:0];
  endfunction

  function automatic int pixval(input int kind, input int r, input int c);
    case (kind)
      0:       return r * 10;
      1:       return c * 10;
      2:       return (r >= 3) ? 255 : 0;
      3:       return (r >= 3) ? 0 : 255;
      default: return int'($urandom_range(255));
    endcase
  endfunction

  // checks all outputs #1 after each edge against the expected queue
  task automatic sample();
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      chk("valid", 32'(out_valid), 32'd1);
      chk("grad", 32'(out_grad), 32'(e.g));
      chk("eol", 32'(out_eol), 32'(e.eol));
      chk("eof", 32'(out_eof), 32'(e.eof));
      last_grad = e.g;
    end else begin
      chk("idle_valid", 32'(out_valid), 32'd0);
      chk("idle_eol", 32'(out_eol), 32'd0);
      chk("idle_eof", 32'(out_eof), 32'd0);
      chk("hold_grad", 32'(out_grad), 32'(last_grad));
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_pix   = PW'($urandom);
    in_sof   = 1'($urandom);
    mode     = 2'($urandom);
    @(posedge clk);
    cyc++;
    #1 sample();
  endtask

  task automatic send(input int r, input int c, input int p,
                      input logic sof, input logic [1:0] md,
                      input logic [1:0] fmode);
    exp_t e;
    in_valid = 1'b1;
    in_pix   = PW'(p);
    in_sof   = sof;
    mode     = sof ? md : 2'($urandom);
    @(posedge clk);
    cyc++;
    frame[r][c] = p;
    if (r >= 2 && c >= 2) begin
      e.due = cyc + 2;
      e.g   = model(r, c, fmode);
      e.eol = (c == W - 1);
      e.eof = (c == W - 1) && (r == H - 1);
      exp_q.push_back(e);
    end
    #1 sample();
  endtask

  task automatic send_frame(input int kind, input logic [1:0] md,
                            input int gap, input int npix,
                            input logic use_sof);
    int n;
    n = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (n < npix) begin
          for (int k = 0; k < 8 && int'($urandom_range(99)) < gap; k++)
            idle();
          send(r, c, pixval(kind, r, c), use_sof && n == 0, md, md);
          n++;
        end
      end
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 4; k++) idle();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    cyc = 0;
    vectors = 0;
    miscompares = 0;
    last_grad = '0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_pix = '0;
    in_sof = 1'b0;
    mode = 2'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_grad", 32'(out_grad), 32'd0);
    chk("rst_eol", 32'(out_eol), 32'd0);
    chk("rst_eof", 32'(out_eof), 32'd0);
    rst = 1'b0;

    // vertical ramp, first frame after reset without in_sof
    send_frame(0, 2'd0, 0, W * H, 1'b0);
    drain();
    // horizontal ramp, Gx then Gy
    send_frame(1, 2'd1, 0, W * H, 1'b1);
    send_frame(1, 2'd0, 0, W * H, 1'b1);
    drain();
    // step edge, magnitude then Gy, then inverted step
    send_frame(2, 2'd2, 0, W * H, 1'b1);
    send_frame(2, 2'd0, 0, W * H, 1'b1);
    send_frame(3, 2'd0, 0, W * H, 1'b1);
    drain();
    // vertical ramp with random 50% gaps
    send_frame(0, 2'd0, 50, W * H, 1'b1);
    drain();
    // random pixels in all modes with gaps
    send_frame(4, 2'd1, 30, W * H, 1'b1);
    send_frame(4, 2'd3, 30, W * H, 1'b1);
    send_frame(4, 2'd0, 0, W * H, 1'b1);
    drain();

    // reset pulse after 20 pixels
    send_frame(4, 2'd2, 0, 20, 1'b1);
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_grad", 32'(out_grad), 32'd0);
    chk("arst_eol", 32'(out_eol), 32'd0);
    exp_q.delete();
    last_grad = '0;
    idle();
    idle();
    rst = 1'b0;
    send_frame(4, 2'd2, 20, W * H, 1'b1);
    drain();

    // abort at row 3 col 4: sof with mode change 0 -> 2
    send_frame(0, 2'd0, 0, 3 * W + 4, 1'b1);
    send_frame(4, 2'd2, 0, W * H, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
